// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst master.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  // Higher encoding is the more severe response (DECERR > SLVERR > OKAY).
  function automatic logic [1:0] worse_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 master: one INCR burst of 4-byte beats in flight, write data
// and read data streamed straight through to the user side.
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  last_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic                  WLAST,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(3);

  state_t                  state_reg;
  logic                    alive_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [7:0]              len_reg;
  logic [7:0]              beat_cnt_reg;
  logic [1:0]              worst_reg;

  logic in_w, in_r, last_beat, w_beat, r_beat;
  logic [1:0] beat_resp;

  assign in_w      = (state_reg == ST_W);
  assign in_r      = (state_reg == ST_R);
  assign last_beat = (beat_cnt_reg == 8'd0);

  // alive_reg keeps cmd_ready low while reset is held and until the first clean edge.
  assign cmd_ready = alive_reg && (state_reg == ST_IDLE);

  assign AWADDR  = addr_reg;
  assign AWLEN   = len_reg;
  assign AWSIZE  = SIZE_4B;
  assign AWVALID = (state_reg == ST_AW);
  assign ARADDR  = addr_reg;
  assign ARLEN   = len_reg;
  assign ARSIZE  = SIZE_4B;
  assign ARVALID = (state_reg == ST_AR);
  assign BREADY  = (state_reg == ST_B);

  assign WVALID   = in_w & wd_valid;
  assign WDATA    = in_w ? wd_data : '0;
  assign WLAST    = in_w & last_beat;
  assign wd_ready = in_w & WREADY;

  assign RREADY   = in_r & rd_ready;
  assign rd_valid = in_r & RVALID;
  assign rd_data  = in_r ? RDATA : '0;
  assign rd_resp  = in_r ? RRESP : 2'b00;
  assign rd_last  = in_r & RLAST;

  assign w_beat    = WVALID & WREADY;
  assign r_beat    = RVALID & RREADY;
  assign beat_resp = worse_resp(worst_reg, RRESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= ST_IDLE;
      alive_reg    <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= 8'd0;
      beat_cnt_reg <= 8'd0;
      worst_reg    <= RESP_OKAY;
      done         <= 1'b0;
      done_resp    <= RESP_OKAY;
      last_err     <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      done      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_reg     <= cmd_addr & ~ALIGN_MASK;
            len_reg      <= cmd_len;
            beat_cnt_reg <= cmd_len;
            worst_reg    <= RESP_OKAY;
            last_err     <= 1'b0;
            state_reg    <= cmd_write ? ST_AW : ST_AR;
          end
        end
        ST_AW: if (AWREADY) state_reg <= ST_W;
        ST_W: begin
          if (w_beat) begin
            if (last_beat) state_reg <= ST_B;
            else beat_cnt_reg <= beat_cnt_reg - 8'd1;
          end
        end
        ST_B: begin
          if (BVALID) begin
            done      <= 1'b1;
            done_resp <= BRESP;
            state_reg <= ST_IDLE;
          end
        end
        ST_AR: if (ARREADY) state_reg <= ST_R;
        ST_R: begin
          if (r_beat) begin
            worst_reg <= beat_resp;
            // The burst length is owned by our counter; a disagreeing RLAST is only flagged.
            if (RLAST != last_beat) last_err <= 1'b1;
            if (last_beat) begin
              done      <= 1'b1;
              done_resp <= beat_resp;
              state_reg <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg - 8'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench: bench-side AXI slave (1024 words), protocol-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_axi4_burst_master;
  import axi4_master_pkg::*;

  localparam int DEPTH = 1024;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0] cmd_len;
  logic wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic [1:0] rd_resp;
  logic done, last_err;
  logic [1:0] done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0] BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_burst_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .last_err(last_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] slv_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  // ---------------- slave: drives at negedge, observes handshakes at negedge+1
  int aw_delay = 2;
  int early_last = -1;
  int aw_wait, w_word, r_word, r_len, r_beat;
  logic w_err, b_pend, r_act;

  initial begin
    AWREADY = 0; WREADY = 1; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    aw_wait = 0; w_word = 0; r_word = 0; r_len = 0; r_beat = 0;
    w_err = 0; b_pend = 0; r_act = 0;
    forever begin
      @(negedge ACLK);
      AWREADY = AWVALID && (aw_wait >= aw_delay);
      ARREADY = ARVALID;
      BVALID  = b_pend;
      BRESP   = w_err ? 2'b10 : 2'b00;
      RVALID  = r_act;
      RDATA   = (r_word < DEPTH) ? slv_mem[r_word] : 32'h0;
      RRESP   = (r_word < DEPTH) ? 2'b00 : 2'b10;
      RLAST   = r_act && (r_beat == r_len || r_beat == early_last);
      #1;
      if (!ARESETn) begin
        AWREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RLAST = 0;
        aw_wait = 0; w_err = 0; b_pend = 0; r_act = 0;
        continue;
      end
      if (AWVALID && AWREADY) begin w_word = int'(AWADDR >> 2); aw_wait = 0; end
      else if (AWVALID) aw_wait++;
      if (WVALID && WREADY) begin
        if (w_word < DEPTH) slv_mem[w_word] = WDATA; else w_err = 1;
        w_word++;
        if (WLAST) b_pend = 1;
      end
      if (BVALID && BREADY) begin b_pend = 0; w_err = 0; end
      if (ARVALID && ARREADY) begin
        r_act = 1; r_word = int'(ARADDR >> 2); r_len = int'(ARLEN); r_beat = 0;
      end
      if (RVALID && RREADY) begin
        if (r_beat == r_len) r_act = 0;
        r_beat++; r_word++;
      end
    end
  end

  // ---------------- reference model: protocol phases of the single command in flight
  logic m_alive = 0, m_busy = 0, m_write = 0, m_done_due = 0, m_last_err = 0;
  logic [15:0] m_addr = 0;
  logic [7:0] m_len = 0;
  logic [1:0] m_resp = 0;
  int m_phase = 0, m_beat = 0;

  initial begin
    logic wph, rph;
    int word;
    forever begin
      @(negedge ACLK);
      #2;
      if (!ARESETn) begin
        chk("rst_ctrl", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, rd_valid,
                         rd_last, wd_ready, cmd_ready, done, last_err}, 0);
        chk("rst_addr", {AWADDR, ARADDR, AWLEN, ARLEN}, 0);
        chk("rst_data", {WDATA, rd_data}, 0);
        chk("rst_done_resp", done_resp, 0);
        m_alive = 0; m_busy = 0; m_done_due = 0; m_last_err = 0;
        continue;
      end
      wph  = m_busy && m_write && m_phase == 1;
      rph  = m_busy && !m_write && m_phase == 1;
      word = int'(m_addr >> 2) + m_beat;
      chk("cmd_ready", cmd_ready, m_alive && !m_busy);
      chk("awvalid", AWVALID, m_busy && m_write && m_phase == 0);
      if (AWVALID) chk("aw_fields", {AWADDR, AWLEN, AWSIZE}, {m_addr, m_len, 3'b010});
      chk("arvalid", ARVALID, m_busy && !m_write && m_phase == 0);
      if (ARVALID) chk("ar_fields", {ARADDR, ARLEN, ARSIZE}, {m_addr, m_len, 3'b010});
      chk("wvalid", WVALID, wph && wd_valid);
      chk("wd_ready", wd_ready, wph && WREADY);
      chk("wdata", WDATA, wph ? wd_data : 32'h0);
      chk("wlast", WLAST, wph && m_beat == int'(m_len));
      chk("bready", BREADY, m_busy && m_write && m_phase == 2);
      chk("rready", RREADY, rph && rd_ready);
      chk("rd_valid", rd_valid, rph && RVALID);
      if (rd_valid)
        chk("rd_beat", {rd_data, rd_resp, rd_last},
            {(word < DEPTH) ? ref_mem[word] : 32'h0, (word < DEPTH) ? 2'b00 : 2'b10, RLAST});
      chk("done", done, m_done_due);
      if (m_done_due) chk("done_resp", done_resp, m_resp);
      chk("last_err", last_err, m_last_err);
      // advance model by the handshakes that the next rising edge will take
      m_done_due = 0;
      if (m_busy && m_phase == 0 && ((m_write && AWVALID && AWREADY) || (!m_write && ARVALID && ARREADY)))
        m_phase = 1;
      else if (wph && WVALID && WREADY) begin
        if (word < DEPTH) ref_mem[word] = wd_data;
        if (m_beat == int'(m_len)) m_phase = 2;
        m_beat++;
      end else if (m_busy && m_write && m_phase == 2 && BVALID && BREADY) begin
        m_busy = 0; m_done_due = 1;
      end else if (rph && RVALID && RREADY) begin
        if (RLAST != (m_beat == int'(m_len))) m_last_err = 1;
        if (m_beat == int'(m_len)) begin m_busy = 0; m_done_due = 1; end
        m_beat++;
      end
      if (cmd_valid && cmd_ready) begin
        m_busy = 1; m_write = cmd_write; m_addr = {cmd_addr[15:2], 2'b00}; m_len = cmd_len;
        m_phase = 0; m_beat = 0; m_last_err = 0;
        m_resp = (int'(cmd_addr >> 2) + int'(cmd_len) >= DEPTH) ? 2'b10 : 2'b00;
      end
      m_alive = 1;
    end
  end

  // ---------------- command driver
  logic got_done;
  logic [1:0] got_resp;
  logic got_lerr;
  logic [31:0] rd_seen [$];

  task automatic do_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                        input logic throttle, input int rst_beat, output int beats, output int lasts);
    logic got;
    int cyc;
    beats = 0; lasts = 0; got = 0; cyc = 0;
    got_done = 0; got_resp = 0; got_lerr = 0;
    rd_seen.delete();
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    for (int i = 0; i < 100 && !got; i++) begin
      if (i > 0) @(negedge ACLK);
      #1 got = cmd_ready;
    end
    if (!got) begin
      cmd_valid = 0;
      chk("cmd_accept_timeout", 0, 1);
      return;
    end
    while (!got_done && cyc < 3000) begin
      @(negedge ACLK);
      cmd_valid = 0;
      wd_valid  = wr;
      wd_data   = 32'hD000_0000 + (32'(addr) << 8) + 32'(beats);
      rd_ready  = throttle ? cyc[0] : 1'b1;
      if (rst_beat >= 0 && beats == rst_beat) begin
        ARESETn = 0;
        break;
      end
      #1;
      if (wd_valid && wd_ready) begin lasts += 32'(WLAST); beats++; end
      if (rd_valid && rd_ready) begin rd_seen.push_back(rd_data); lasts += 32'(rd_last); beats++; end
      if (done) begin got_done = 1; got_resp = done_resp; got_lerr = last_err; end
      cyc++;
    end
    wd_valid = 0; rd_ready = 0;
    if (rst_beat < 0 && !got_done) chk("done_timeout", 0, 1);
    $display("[TB] %s addr=%h len=%0d beats=%0d lasts=%0d done=%b resp=%b last_err=%b",
             wr ? "WR" : "RD", addr, len, beats, lasts, got_done, got_resp, got_lerr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, l;
    for (int i = 0; i < DEPTH; i++) begin
      slv_mem[i] = 32'h5A00_0000 + 32'(i);
      ref_mem[i] = 32'h5A00_0000 + 32'(i);
    end
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wd_valid = 0; wd_data = 0; rd_ready = 0;
    ARESETn = 1;
    #1 ARESETn = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;

    // write 0x0010 len 3, AWREADY after 2 cycles
    do_cmd(1, 16'h0010, 8'd3, 0, -1, b, l);
    chk("wr4_beats", b, 4); chk("wr4_wlast_cnt", l, 1);
    chk("wr4_done", got_done, 1); chk("wr4_resp", got_resp, 2'b00);

    // read it back
    do_cmd(0, 16'h0010, 8'd3, 0, -1, b, l);
    chk("rd4_beats", b, 4); chk("rd4_last_cnt", l, 1); chk("rd4_resp", got_resp, 2'b00);
    for (int i = 0; i < 4; i++)
      chk("rd4_data", (i < rd_seen.size()) ? rd_seen[i] : 32'h0, 32'hD000_1000 + 32'(i));

    // write past the end of slave memory
    do_cmd(1, 16'h0FFC, 8'd7, 0, -1, b, l);
    chk("wr_oor_beats", b, 8); chk("wr_oor_resp", got_resp, 2'b10);

    // 256-beat read with rd_ready toggling
    do_cmd(0, 16'h0100, 8'd255, 1, -1, b, l);
    chk("rd256_beats", b, 256); chk("rd256_last_cnt", l, 1);
    chk("rd256_seen", rd_seen.size(), 256);
    for (int k = 0; k < 256; k++)
      chk("rd256_data", (k < rd_seen.size()) ? rd_seen[k] : 32'h0, 32'h5A00_0040 + 32'(k));

    // early RLAST on beat 2 of a 4-beat read
    early_last = 1;
    do_cmd(0, 16'h0010, 8'd3, 0, -1, b, l);
    early_last = -1;
    chk("early_beats", b, 4); chk("early_last_err", got_lerr, 1); chk("early_done", got_done, 1);

    // single-beat write and read back-to-back; last_err clears on accept
    do_cmd(1, 16'h0041, 8'd0, 0, -1, b, l);
    chk("wr1_beats", b, 1); chk("wr1_wlast_cnt", l, 1); chk("wr1_last_err", got_lerr, 0);
    do_cmd(0, 16'h0040, 8'd0, 0, -1, b, l);
    chk("rd1_beats", b, 1);
    chk("rd1_data", (rd_seen.size() > 0) ? rd_seen[0] : 32'h0, 32'hD000_4100);

    // reset asserted while the 3rd write beat is presented
    aw_delay = 0;
    do_cmd(1, 16'h0200, 8'd5, 0, 2, b, l);
    chk("rst_beats_before", b, 2); chk("rst_no_done", got_done, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    do_cmd(1, 16'h0300, 8'd1, 0, -1, b, l);
    chk("post_rst_beats", b, 2); chk("post_rst_resp", got_resp, 2'b00);
    do_cmd(0, 16'h0300, 8'd1, 0, -1, b, l);
    for (int i = 0; i < 2; i++)
      chk("post_rst_data", (i < rd_seen.size()) ? rd_seen[i] : 32'h0, 32'hD003_0000 + 32'(i));

    repeat (3) @(negedge ACLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_burst_master.md
AXI4_BURST_MASTER -- requirements
Module: axi4_burst_master

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, byte address width of AW/AR channels.
REQ-002 Parameter: DATA_WIDTH, 32, width of WDATA/RDATA.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETn  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  in  ADDR_WIDTH  byte start address.
REQ-008 cmd_len  in  8  AXI length; beats = cmd_len+1.
REQ-009 wd_valid / wd_ready / wd_data  in / out / in  1 / 1 / DATA_WIDTH  write-data stream.
REQ-010 rd_valid / rd_ready / rd_data / rd_resp / rd_last  out / in / out / out / out  1 / 1 / DATA_WIDTH / 2 / 1  read-data stream.
REQ-011 done / done_resp / last_err  out  1 / 2 / 1  end-of-command pulse, worst response, RLAST-mismatch flag.
REQ-012 Full AXI4 master AW/W/B/AR/R ports: AWADDR, AWLEN[7:0], AWSIZE[2:0], AWVALID, AWREADY, WDATA, WVALID, WREADY, WLAST, BRESP[1:0], BVALID, BREADY, ARADDR, ARLEN, ARSIZE, ARVALID, ARREADY, RDATA, RRESP, RLAST, RVALID, RREADY.

Function
REQ-013 FSM states: IDLE, AW, W, B, AR, R; one command in flight.
REQ-014 cmd_ready = 1 only in IDLE; command accepted on cmd_valid && cmd_ready, registered next edge.
REQ-015 Accept with cmd_write=1 -> AW; cmd_write=0 -> AR.
REQ-016 AWADDR/ARADDR = {cmd_addr[ADDR_WIDTH-1:2], 2'b00}; AWLEN/ARLEN = cmd_len; AWSIZE/ARSIZE = 3'b010.
REQ-017 AWVALID/ARVALID high throughout AW/AR; address/len stable until READY; AW -> W on AWREADY; AR -> R on ARREADY.
REQ-018 In W: WVALID = wd_valid, WDATA = wd_data, wd_ready = WREADY (combinational pass-through); zero outside W.
REQ-019 8-bit beat counter loaded with cmd_len, decremented per W beat; WLAST = (counter == 0) in W.
REQ-020 W -> B on the WLAST beat; BREADY = 1 only in B; B -> IDLE on BVALID, done pulses one cycle, done_resp = BRESP.
REQ-021 In R: rd_valid = RVALID, rd_data = RDATA, rd_resp = RRESP, rd_last = RLAST, RREADY = rd_ready.
REQ-022 Read beat counter as REQ-019; on final counted beat R -> IDLE, done pulses, done_resp = worst RRESP of burst (SLVERR 2'b10 dominates OKAY).
REQ-023 last_err set if RLAST differs from (counter == 0) on any R beat; cleared on next command accept.
REQ-024 cmd_len = 0: single beat, WLAST on first beat; cmd_len = 255: 256 beats, no counter wrap.
REQ-025 Back-to-back: new command may be accepted the cycle after done.

Reset
REQ-026 ARESETn low, any state: FSM -> IDLE immediately; all VALID/READY/LAST outputs, done, last_err = 0; address/len/data outputs = 0; done_resp = 2'b00.
REQ-027 Reset mid-burst abandons the burst without done pulse; cmd_ready = 1 on first edge after deassertion.

Structure
REQ-028 Package axi4_master_pkg holds state enum, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, SIZE_4B = 3'b010.
REQ-029 Single module, no sub-module.

Verification
REQ-030 Write addr 0x0010, len 3, AWREADY after 2 cycles, WREADY always 1 -> 4 W beats, WLAST on 4th only, done=1 with done_resp 2'b00.
REQ-031 Read addr 0x0010, len 3 from slave with MEMORY_DEPTH 1024 -> 4 rd beats matching written data, rd_last on 4th, done_resp 2'b00.
REQ-032 Write addr 0x0FFC, len 7 (exceeds depth) -> BRESP 2'b10 propagates, done_resp 2'b10.
REQ-033 Read len 255 with RREADY throttled by rd_ready toggling -> exactly 256 beats, no beat lost or duplicated.
REQ-034 ARESETn asserted on 3rd W beat -> all VALIDs 0 same cycle, no done; next command accepted normally.
REQ-035 Slave RLAST early on beat 2 of len 3 -> last_err = 1, burst still completes 4 beats.
